// File: rtl/layer_sequencer_pkg.sv
// Shared definitions for the layer sequencer: default sizing, FSM state
// encoding and a width helper used by the top and the result serializer.
package layer_sequencer_pkg;

  localparam int DEF_NUM_NEURON     = 30;
  localparam int DEF_NUM_WEIGHT     = 784;
  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1023;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  // Index width that stays legal for a single-entry range.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_sequencer_result_serializer.sv
// Captures the packed neuron results once and hands them out one word per
// downstream handshake, neuron 0 first, flagging the final word.
module result_serializer
  import layer_sequencer_pkg::*;
#(
  parameter int numNeuron = DEF_NUM_NEURON,
  parameter int dataWidth = DEF_DATA_WIDTH
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           capture_i,
  input  logic [numNeuron*dataWidth-1:0] n_out_i,
  input  logic                           out_ready_i,
  output logic [dataWidth-1:0]           out_data_o,
  output logic                           out_valid_o,
  output logic                           out_last_o,
  output logic                           done_o
);

  localparam int IDX_W = idx_width(numNeuron);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(numNeuron - 1);

  logic [numNeuron*dataWidth-1:0] buf_q, buf_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [IDX_W-1:0]               idx_inc_s;
  logic [dataWidth-1:0]           data_q, data_d;
  logic                           valid_q, valid_d;
  logic                           last_q, last_d;
  logic                           done_s;

  // Next-state: load on capture, otherwise step only on a downstream handshake.
  always_comb begin
    buf_d     = buf_q;
    idx_d     = idx_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    done_s    = 1'b0;
    idx_inc_s = idx_q + 1'b1;
    if (capture_i) begin
      buf_d   = n_out_i;
      idx_d   = {IDX_W{1'b0}};
      data_d  = n_out_i[dataWidth-1:0];
      valid_d = 1'b1;
      last_d  = (LAST_IDX == {IDX_W{1'b0}});
    end else if (valid_q && out_ready_i) begin
      if (last_q) begin
        idx_d   = {IDX_W{1'b0}};
        data_d  = {dataWidth{1'b0}};
        valid_d = 1'b0;
        last_d  = 1'b0;
        done_s  = 1'b1;
      end else begin
        idx_d  = idx_inc_s;
        data_d = buf_q[int'(idx_inc_s)*dataWidth +: dataWidth];
        last_d = (idx_inc_s == LAST_IDX);
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Serializer state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q   <= {(numNeuron*dataWidth){1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      data_q  <= {dataWidth{1'b0}};
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;
  assign out_last_o  = last_q;
  assign done_o      = done_s;

endmodule

// File: rtl/layer_sequencer.sv
// Streams one input vector to a neuron layer, waits for all neuron results,
// then serializes them downstream; timeouts and partial results set err.
module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter int numNeuron     = DEF_NUM_NEURON,
  parameter int numWeight     = DEF_NUM_WEIGHT,
  parameter int dataWidth     = DEF_DATA_WIDTH,
  parameter int timeoutCycles = DEF_TIMEOUT_CYCLES
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [dataWidth-1:0]           in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [dataWidth-1:0]           n_data,
  output logic                           n_valid,
  input  logic [numNeuron*dataWidth-1:0] n_out,
  input  logic [numNeuron-1:0]           n_outvalid,
  output logic [dataWidth-1:0]           out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic                           busy,
  output logic                           err
);

  localparam int CNT_W = $clog2(numWeight + 1);
  localparam int TO_W  = $clog2(timeoutCycles + 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(numWeight - 1);
  localparam logic [TO_W-1:0]  LAST_WAIT = TO_W'(timeoutCycles - 1);

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     in_cnt_q, in_cnt_d;
  logic [TO_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic                 err_q, err_d;
  logic [dataWidth-1:0] n_data_q;
  logic                 n_valid_q;
  logic                 in_ready_s;
  logic                 in_hs_s;
  logic                 all_valid_s;
  logic                 any_valid_s;
  logic                 capture_s;
  logic                 drain_done_s;

  assign in_ready_s  = (state_q == ST_IDLE) || (state_q == ST_STREAM);
  assign in_hs_s     = in_valid && in_ready_s;
  assign all_valid_s = &n_outvalid;
  assign any_valid_s = |n_outvalid;

  // Sequencer FSM; a complete result set wins over a same-cycle timeout.
  always_comb begin
    state_d    = state_q;
    in_cnt_d   = in_cnt_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    capture_s  = 1'b0;
    case (state_q)
      ST_IDLE, ST_STREAM: begin
        if (in_hs_s) begin
          if (in_cnt_q == LAST_CNT) begin
            state_d    = ST_WAIT;
            in_cnt_d   = {CNT_W{1'b0}};
            wait_cnt_d = {TO_W{1'b0}};
          end else begin
            state_d  = ST_STREAM;
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (all_valid_s) begin
          capture_s = 1'b1;
          state_d   = ST_DRAIN;
        end else if (any_valid_s || (wait_cnt_q == LAST_WAIT)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (drain_done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, counters and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      in_cnt_q   <= {CNT_W{1'b0}};
      wait_cnt_q <= {TO_W{1'b0}};
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_cnt_q   <= in_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  // Broadcast register: each accepted word is presented to the neurons one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_data_q  <= {dataWidth{1'b0}};
      n_valid_q <= 1'b0;
    end else begin
      if (in_hs_s) begin
        n_data_q <= in_data;
      end
      n_valid_q <= in_hs_s;
    end
  end

  result_serializer #(
    .numNeuron (numNeuron),
    .dataWidth (dataWidth)
  ) u_result_serializer (
    .clk_i       (clk),
    .rst_ni      (rst),
    .capture_i   (capture_s),
    .n_out_i     (n_out),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_last_o  (out_last),
    .done_o      (drain_done_s)
  );

  assign in_ready = in_ready_s;
  assign n_data   = n_data_q;
  assign n_valid  = n_valid_q;
  assign busy     = (state_q != ST_IDLE);
  assign err      = err_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: stimulus pushes expected broadcast
// words and serialized results into queues, monitors pop and compare.
module tb_layer_sequencer;

  localparam int NN = 3;
  localparam int NW = 4;
  localparam int DW = 16;
  localparam int TO = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [DW-1:0]    in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    n_data;
  logic             n_valid;
  logic [NN*DW-1:0] n_out = '0;
  logic [NN-1:0]    n_outvalid = '0;
  logic [DW-1:0]    out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_last;
  logic             busy;
  logic             err;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;

  typedef struct { logic [DW-1:0] data; int cyc; } nexp_t;
  typedef struct { logic [DW-1:0] data; logic last; } oexp_t;
  nexp_t n_q[$];
  oexp_t o_q[$];

  logic          stall_q = 1'b0;
  logic [DW-1:0] stall_data = '0;
  logic          stall_last = 1'b0;

  layer_sequencer #(
    .numNeuron     (NN),
    .numWeight     (NW),
    .dataWidth     (DW),
    .timeoutCycles (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .n_data     (n_data),
    .n_valid    (n_valid),
    .n_out      (n_out),
    .n_outvalid (n_outvalid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Broadcast monitor: every n_valid pulse must match the next accepted word, one cycle late.
  always @(negedge clk) begin
    nexp_t e;
    if (n_valid) begin
      if (n_q.size() == 0) begin
        check("n_valid_unexpected", 32'(n_valid), 32'd0);
      end else begin
        e = n_q.pop_front();
        check("n_data", 32'(n_data), 32'(e.data));
        check("n_valid_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Result monitor: in-order words, last flag, and stability across stalls.
  always @(negedge clk) begin
    oexp_t e;
    if (stall_q) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'(out_data), 32'(stall_data));
      check("hold_last", 32'(out_last), 32'(stall_last));
    end
    if (out_valid && out_ready) begin
      if (o_q.size() == 0) begin
        check("out_unexpected", 32'(out_valid), 32'd0);
      end else begin
        e = o_q.pop_front();
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_last", 32'(out_last), 32'(e.last));
      end
    end
    stall_q    <= out_valid && !out_ready;
    stall_data <= out_data;
    stall_last <= out_last;
  end

  task automatic send_word(input logic [DW-1:0] d);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      n_q.push_back('{data: d, cyc: cyc + 1});
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [NW*DW-1:0] words, input int max_gap);
    for (int i = 0; i < NW; i++) begin
      repeat ($urandom_range(0, max_gap)) tick();
      send_word(words[i*DW +: DW]);
    end
    check("in_ready_after_vector", 32'(in_ready), 32'd0);
    check("busy_after_vector", 32'(busy), 32'd1);
  endtask

  task automatic respond(input logic [NN*DW-1:0] vals, input int delay);
    repeat (delay) tick();
    n_out      = vals;
    n_outvalid = {NN{1'b1}};
    for (int i = 0; i < NN; i++) begin
      o_q.push_back('{data: vals[i*DW +: DW], last: (i == NN - 1)});
    end
    tick();
  endtask

  task automatic drain(input int mode);
    int pat[5] = '{1, 0, 0, 1, 1};
    int k = 0;
    while (o_q.size() > 0 && k < 200) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = pat[k % 5][0];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      n_outvalid = NN'($urandom_range(0, 7));
      n_out      = {NN{DW'($urandom)}};
      tick();
      k++;
    end
    if (k >= 200) check("drain_timeout", 32'(o_q.size()), 32'd0);
    n_outvalid = '0;
    out_ready  = 1'b0;
    check("busy_after_drain", 32'(busy), 32'd0);
    check("out_valid_after_drain", 32'(out_valid), 32'd0);
  endtask

  task automatic run_txn(input logic [NW*DW-1:0] words, input logic [NN*DW-1:0] vals,
                         input int max_gap, input int delay, input int mode);
    send_vec(words, max_gap);
    respond(vals, delay);
    drain(mode);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_n_valid", 32'(n_valid), 32'd0);
    check("rst_n_data", 32'(n_data), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  function automatic logic [NW*DW-1:0] rand_words();
    logic [NW*DW-1:0] w;
    for (int i = 0; i < NW; i++) w[i*DW +: DW] = DW'($urandom);
    return w;
  endfunction

  function automatic logic [NN*DW-1:0] rand_vals();
    logic [NN*DW-1:0] v;
    for (int i = 0; i < NN; i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Back-to-back 1..4, full result set, always ready.
    run_txn({16'd4, 16'd3, 16'd2, 16'd1}, {16'h0030, 16'h0020, 16'h0010}, 0, 2, 0);

    // Downstream stalls 1,0,0,1,1.
    run_txn(rand_words(), rand_vals(), 1, 3, 1);

    // Partial n_outvalid in WAIT.
    send_vec(rand_words(), 1);
    repeat (3) tick();
    n_out      = rand_vals();
    n_outvalid = 3'b101;
    tick();
    n_outvalid = '0;
    check("partial_err", 32'(err), 32'd1);
    check("partial_busy", 32'(busy), 32'd0);
    check("partial_out_valid", 32'(out_valid), 32'd0);
    repeat (4) tick();
    check("partial_err_sticky", 32'(err), 32'd1);
    do_reset();

    // Timeout: nothing for the whole WAIT window.
    send_vec(rand_words(), 0);
    repeat (TO - 1) tick();
    check("timeout_busy_before", 32'(busy), 32'd1);
    check("timeout_err_before", 32'(err), 32'd0);
    tick();
    check("timeout_err", 32'(err), 32'd1);
    check("timeout_busy", 32'(busy), 32'd0);
    do_reset();

    // Reset mid-stream: two words discarded, a fresh vector completes normally.
    send_word(16'h1111);
    send_word(16'h2222);
    tick();
    do_reset();
    run_txn(rand_words(), rand_vals(), 0, 1, 0);
    check("post_reset_err", 32'(err), 32'd0);

    // Randomized transactions.
    for (int t = 0; t < 6; t++) begin
      run_txn(rand_words(), rand_vals(), 2, $urandom_range(0, 10), 2);
    end
    check("final_err", 32'(err), 32'd0);

    repeat (3) tick();
    check("n_queue_empty", 32'(n_q.size()), 32'd0);
    check("o_queue_empty", 32'(o_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameter numNeuron, default 30: number of neurons in the sequenced layer.
REQ-002 SHALL have parameter numWeight, default 784: inputs per neuron (input vector length).
REQ-003 SHALL have parameter dataWidth, default 16: width of one data word.
REQ-004 SHALL have parameter timeoutCycles, default 1023: maximum WAIT cycles before error.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port in_data  input  dataWidth  upstream input word.
REQ-008 SHALL have port in_valid  input  1  upstream word valid.
REQ-009 SHALL have port in_ready  output  1  sequencer accepts in_data this cycle.
REQ-010 SHALL have port n_data  output  dataWidth  broadcast word to all neurons' myinput.
REQ-011 SHALL have port n_valid  output  1  broadcast valid to all neurons' myinputValid.
REQ-012 SHALL have port n_out  input  numNeuron*dataWidth  packed neuron outputs, neuron 0 in LSBs.
REQ-013 SHALL have port n_outvalid  input  numNeuron  per-neuron outvalid.
REQ-014 SHALL have port out_data  output  dataWidth  serialized layer result word.
REQ-015 SHALL have port out_valid  output  1  out_data valid.
REQ-016 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-017 SHALL have port out_last  output  1  marks word of neuron numNeuron-1.
REQ-018 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-019 SHALL have port err  output  1  sticky error flag.

Function
REQ-020 SHALL implement FSM states IDLE, STREAM, WAIT, DRAIN.
REQ-021 SHALL assert in_ready in IDLE and in STREAM only; input handshake = in_valid & in_ready.
REQ-022 SHALL, on handshake, register in_data to n_data and pulse n_valid one cycle later (latency 1); n_valid low otherwise; gaps in in_valid permitted.
REQ-023 SHALL move IDLE->STREAM on first handshake; counter in_cnt (width $clog2(numWeight+1)) increments per handshake.
REQ-024 SHALL move STREAM->WAIT on the handshake making in_cnt equal numWeight; in_ready low same cycle onward, in_cnt cleared.
REQ-025 SHALL, in WAIT, capture n_out into an internal buffer and move to DRAIN when n_outvalid is all-ones.
REQ-026 SHALL set err and return to IDLE if n_outvalid is nonzero but not all-ones in WAIT, or WAIT lasts timeoutCycles cycles.
REQ-027 SHALL, in DRAIN, present words in neuron order 0..numNeuron-1; out_valid high throughout DRAIN; index advances only on out_valid & out_ready.
REQ-028 SHALL assert out_last when index equals numNeuron-1; handshake on last word moves DRAIN->IDLE.
REQ-029 SHALL hold out_data/out_valid stable while out_valid & !out_ready (no drop, no duplication).
REQ-030 SHALL ignore n_outvalid outside WAIT; err cleared only by reset.

Reset
REQ-031 SHALL, on rst low, immediately force state IDLE, in_cnt 0, index 0, n_valid 0, out_valid 0, out_last 0, busy 0, err 0, n_data 0, out_data 0; in_ready 1 after release.
REQ-032 SHALL, on reset mid-STREAM/WAIT/DRAIN, discard partial vector and buffered results; first post-reset handshake starts a new vector.

Structure
REQ-033 SHALL take FSM state encoding and default parameter values from the shared include file.
REQ-034 SHALL place the capture buffer and DRAIN index/handshake in one sub-module, result_serializer.

Verification (numNeuron=3, numWeight=4, dataWidth=16, timeoutCycles=20)
REQ-035 SHALL test: 4 back-to-back words 1,2,3,4 -> n_valid pulses 4 cycles each one cycle after handshake, n_data 1..4, in_ready low after 4th.
REQ-036 SHALL test: n_outvalid=3'b111, n_out={0x0030,0x0020,0x0010}, out_ready=1 -> out_data 0x0010,0x0020,0x0030 consecutive, out_last on 3rd, then IDLE.
REQ-037 SHALL test: out_ready toggled 1,0,0,1,1 -> each word held while stalled, exactly 3 transfers.
REQ-038 SHALL test: n_outvalid=3'b101 in WAIT -> err=1 next cycle, state IDLE, no out_valid.
REQ-039 SHALL test: no n_outvalid for 20 WAIT cycles -> err=1, busy=0.
REQ-040 SHALL test: rst low after 2 words, then 4 words -> only post-reset words counted, result drain normal, err=0.
